// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU control unit: sequencer states, opcodes,
// the control-pin bundle and the debug step encoding.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd15
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef struct packed {
    logic pc_out;
    logic zlo_out;
    logic mdr_out;
    logic ba_out;
    logic cse_out;
    logic r_out;
    logic gra;
    logic grb;
    logic mar_en;
    logic z_en;
    logic pc_en;
    logic mdr_en;
    logic ir_en;
    logic y_en;
    logic r_in;
    logic pc_inc;
    logic read;
    logic ram_write;
  } ctrl_t;

  // The state encoding doubles as the debug step number.
  function automatic logic [3:0] t_step_of(input state_e s);
    return 4'(s);
  endfunction

endpackage

// File: rtl/mem_ctrl_sequencer_step_timer.sv
// Per-step clock counter: counts 0..STEP_CYCLES-1, flags the final
// clock, holds there while a step stalls, restarts on step change.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic en_i,
  input  logic adv_i,
  output logic last
);

  localparam int unsigned CW =
    (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] MAX = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || adv_i) begin
      cnt_d = '0;
    end else if (!last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_ctrl_sequencer.sv
// Control-step sequencer for fetch, ld, ldi, st, nop and halt.
// Steps last STEP_CYCLES clocks; memory steps also wait on mem_ready.
module mem_ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned IR_W        = 32,
  parameter int unsigned OPCODE_W    = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [IR_W-1:0] ir,
  input  logic            mem_ready,
  output logic            pc_out,
  output logic            zlo_out,
  output logic            mdr_out,
  output logic            ba_out,
  output logic            c_sign_extended_out,
  output logic            r_out,
  output logic            gra,
  output logic            grb,
  output logic            mar_enable,
  output logic            z_enable,
  output logic            pc_enable,
  output logic            mdr_enable,
  output logic            ir_enable,
  output logic            y_enable,
  output logic            r_in,
  output logic            pc_increment,
  output logic            read,
  output logic            ram_write,
  output logic            running,
  output logic            illegal_op,
  output logic [3:0]      t_step
);

  typedef logic [OPCODE_W-1:0] op_t;
  localparam op_t LD   = op_t'(OP_LD);
  localparam op_t LDI  = op_t'(OP_LDI);
  localparam op_t ST   = op_t'(OP_ST);
  localparam op_t NOP  = op_t'(OP_NOP);
  localparam op_t HALT = op_t'(OP_HALT);

  state_e state_q, state_d;
  op_t    op_q;
  logic   ill_q;
  op_t    ir_op;
  logic   ir_mem, ir_halt, ir_ill;
  logic   in_t, mem_step, last, done;
  ctrl_t  c;
  logic   unused_ir;

  assign ir_op     = ir[IR_W-1 -: OPCODE_W];
  assign unused_ir = ^ir[IR_W-OPCODE_W-1:0];
  assign ir_mem    = ir_op inside {LD, LDI, ST};
  assign ir_halt   = (ir_op == HALT);
  assign ir_ill    = !(ir_mem || ir_halt || ir_op == NOP);

  assign in_t = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign mem_step = (state_q == S_T1)
                 || (state_q == S_T6 && op_q == LD)
                 || (state_q == S_T7 && op_q == ST);
  assign done = last && (!mem_step || mem_ready);

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk   (clk),
    .clr   (clr),
    .en_i  (in_t),
    .adv_i (done),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALTED: if (run) state_d = S_T0;
      S_T0: if (done) state_d = S_T1;
      S_T1: if (done) state_d = S_T2;
      S_T2: if (done) begin
        if (ir_mem)       state_d = S_T3;
        else if (ir_halt) state_d = S_HALTED;
        else              state_d = S_T0;
      end
      S_T3: if (done) state_d = S_T4;
      S_T4: if (done) state_d = S_T5;
      S_T5: if (done) state_d = (op_q == LDI) ? S_T0 : S_T6;
      S_T6: if (done) state_d = S_T7;
      S_T7: if (done) state_d = S_T0;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= NOP;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= (state_q == S_T2) && done && ir_ill;
      if (state_q == S_T2 && done) op_q <= ir_op;
    end
  end

  // Loads fire on the step's closing clock; in memory steps that is
  // the clock the handshake completes, so they follow mem_ready.
  always_comb begin
    c = '0;
    unique case (state_q)
      S_T0: begin
        c.pc_out = 1'b1;
        c.mar_en = done;
        c.pc_inc = done;
        c.z_en   = done;
      end
      S_T1: begin
        c.zlo_out = 1'b1;
        c.read    = 1'b1;
        c.pc_en   = done;
        c.mdr_en  = done;
      end
      S_T2: begin
        c.mdr_out = 1'b1;
        c.ir_en   = done;
      end
      S_T3: begin
        c.grb    = 1'b1;
        c.ba_out = 1'b1;
        c.y_en   = done;
      end
      S_T4: begin
        c.cse_out = 1'b1;
        c.z_en    = done;
      end
      S_T5: begin
        c.zlo_out = 1'b1;
        if (op_q == LDI) begin
          c.gra  = 1'b1;
          c.r_in = done;
        end else begin
          c.mar_en = done;
        end
      end
      S_T6: begin
        if (op_q == LD) begin
          c.read = 1'b1;
        end else begin
          c.gra   = 1'b1;
          c.r_out = 1'b1;
        end
        c.mdr_en = done;
      end
      S_T7: begin
        if (op_q == LD) begin
          c.mdr_out = 1'b1;
          c.gra     = 1'b1;
          c.r_in    = done;
        end else begin
          c.ram_write = 1'b1;
        end
      end
      default: c = '0;
    endcase
  end

  assign pc_out              = c.pc_out;
  assign zlo_out             = c.zlo_out;
  assign mdr_out             = c.mdr_out;
  assign ba_out              = c.ba_out;
  assign c_sign_extended_out = c.cse_out;
  assign r_out               = c.r_out;
  assign gra                 = c.gra;
  assign grb                 = c.grb;
  assign mar_enable          = c.mar_en;
  assign z_enable            = c.z_en;
  assign pc_enable           = c.pc_en;
  assign mdr_enable          = c.mdr_en;
  assign ir_enable           = c.ir_en;
  assign y_enable            = c.y_en;
  assign r_in                = c.r_in;
  assign pc_increment        = c.pc_inc;
  assign read                = c.read;
  assign ram_write           = c.ram_write;
  assign running             = in_t;
  assign illegal_op          = ill_q;
  assign t_step              = t_step_of(state_q);

endmodule

// File: tb/tb_mem_ctrl_sequencer.sv
// Scoreboard bench: stimulus pushes per-clock expected control words,
// a negedge monitor pops and compares them against two DUT instances.
module tb_mem_ctrl_sequencer;

  localparam logic [19:0] PO   = 20'h80000;
  localparam logic [19:0] ZLO  = 20'h40000;
  localparam logic [19:0] MDO  = 20'h20000;
  localparam logic [19:0] BA   = 20'h10000;
  localparam logic [19:0] CSE  = 20'h08000;
  localparam logic [19:0] ROUT = 20'h04000;
  localparam logic [19:0] GRA  = 20'h02000;
  localparam logic [19:0] GRB  = 20'h01000;
  localparam logic [19:0] ME   = 20'h00800;
  localparam logic [19:0] ZE   = 20'h00400;
  localparam logic [19:0] PE   = 20'h00200;
  localparam logic [19:0] MDE  = 20'h00100;
  localparam logic [19:0] IRE  = 20'h00080;
  localparam logic [19:0] YE   = 20'h00040;
  localparam logic [19:0] RIN  = 20'h00020;
  localparam logic [19:0] PI   = 20'h00010;
  localparam logic [19:0] RD   = 20'h00008;
  localparam logic [19:0] WR   = 20'h00004;
  localparam logic [19:0] RN   = 20'h00002;
  localparam logic [19:0] IL   = 20'h00001;

  localparam logic [19:0] F0  = PO | ME | PI | ZE | RN;
  localparam logic [19:0] F1  = ZLO | PE | RD | MDE | RN;
  localparam logic [19:0] F2  = MDO | IRE | RN;
  localparam logic [19:0] X3  = GRB | BA | YE | RN;
  localparam logic [19:0] X4  = CSE | ZE | RN;
  localparam logic [19:0] I5  = ZLO | GRA | RIN | RN;
  localparam logic [19:0] M5  = ZLO | ME | RN;
  localparam logic [19:0] L6  = RD | MDE | RN;
  localparam logic [19:0] L6S = RD | RN;
  localparam logic [19:0] L7  = MDO | GRA | RIN | RN;
  localparam logic [19:0] S6  = GRA | ROUT | MDE | RN;
  localparam logic [19:0] S7  = WR | RN;
  localparam logic [19:0] F1S = ZLO | RD | RN;

  localparam logic [31:0] LDI = 32'h0980_0065;
  localparam logic [31:0] LD  = 32'h0000_0010;
  localparam logic [31:0] ST  = 32'h1000_0020;
  localparam logic [31:0] ILL = 32'hF800_0000;
  localparam logic [31:0] HLT = 32'hD800_0000;
  localparam logic [31:0] NOP = 32'hD000_0000;

  typedef struct {
    int          id;
    logic [3:0]  t;
    logic [19:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run1 = 1'b0;
  logic        run2 = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] ir = '0;
  wire  [19:0] o1, o2;
  wire  [3:0]  ts1, ts2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   row = 0;

  always #5 clk = ~clk;

  mem_ctrl_sequencer #(
    .STEP_CYCLES(1), .IR_W(32), .OPCODE_W(5)
  ) u1 (
    .clk(clk), .clr(clr), .run(run1), .ir(ir),
    .mem_ready(mem_ready),
    .pc_out(o1[19]), .zlo_out(o1[18]), .mdr_out(o1[17]),
    .ba_out(o1[16]), .c_sign_extended_out(o1[15]),
    .r_out(o1[14]), .gra(o1[13]), .grb(o1[12]),
    .mar_enable(o1[11]), .z_enable(o1[10]),
    .pc_enable(o1[9]), .mdr_enable(o1[8]),
    .ir_enable(o1[7]), .y_enable(o1[6]), .r_in(o1[5]),
    .pc_increment(o1[4]), .read(o1[3]),
    .ram_write(o1[2]), .running(o1[1]),
    .illegal_op(o1[0]), .t_step(ts1)
  );

  mem_ctrl_sequencer #(
    .STEP_CYCLES(2), .IR_W(32), .OPCODE_W(5)
  ) u2 (
    .clk(clk), .clr(clr), .run(run2), .ir(ir),
    .mem_ready(mem_ready),
    .pc_out(o2[19]), .zlo_out(o2[18]), .mdr_out(o2[17]),
    .ba_out(o2[16]), .c_sign_extended_out(o2[15]),
    .r_out(o2[14]), .gra(o2[13]), .grb(o2[12]),
    .mar_enable(o2[11]), .z_enable(o2[10]),
    .pc_enable(o2[9]), .mdr_enable(o2[8]),
    .ir_enable(o2[7]), .y_enable(o2[6]), .r_in(o2[5]),
    .pc_increment(o2[4]), .read(o2[3]),
    .ram_write(o2[2]), .running(o2[1]),
    .illegal_op(o2[0]), .t_step(ts2)
  );

  task automatic chk(input int d, input exp_t x,
                     input logic [3:0] t, input logic [19:0] v);
    checks++;
    if (t !== x.t || v !== x.v) begin
      errors++;
      $display("FAIL dut%0d row %0d: t_step=%0d ctrl=%05h, want t_step=%0d ctrl=%05h",
               d, x.id, t, v, x.t, x.v);
    end
  endtask

  always @(negedge clk) begin
    if (q1.size() != 0) begin
      e = q1.pop_front();
      chk(1, e, ts1, o1);
    end
    if (q2.size() != 0) begin
      e = q2.pop_front();
      chk(2, e, ts2, o2);
    end
  end

  // Inputs apply to the clock just started; expectation is that clock's outputs.
  task automatic cyc1(input logic r, input logic c, input logic m,
                      input logic [31:0] i, input logic [3:0] t,
                      input logic [19:0] v);
    @(posedge clk);
    #1;
    run1 = r; run2 = 1'b0; clr = c; mem_ready = m; ir = i;
    row++;
    q1.push_back('{row, t, v});
  endtask

  task automatic cyc2(input logic r, input logic [31:0] i,
                      input logic [3:0] t, input logic [19:0] v);
    @(posedge clk);
    #1;
    run1 = 1'b0; run2 = r; clr = 1'b0; mem_ready = 1'b1; ir = i;
    row++;
    q2.push_back('{row, t, v});
  endtask

  initial begin
    cyc1(0, 1, 1, LDI, 0, 0);
    cyc1(0, 1, 1, LDI, 0, 0);
    cyc1(0, 0, 1, LDI, 0, 0);
    cyc1(1, 0, 1, LDI, 0, 0);
    cyc1(0, 0, 1, LDI, 1, F0);
    cyc1(0, 0, 1, LDI, 2, F1);
    cyc1(0, 0, 1, LDI, 3, F2);
    cyc1(0, 0, 1, LD, 4, X3);
    cyc1(0, 0, 1, LD, 5, X4);
    cyc1(0, 0, 1, LD, 6, I5);
    cyc1(0, 0, 1, LD, 1, F0);
    cyc1(0, 0, 1, LD, 2, F1);
    cyc1(0, 0, 1, LD, 3, F2);
    cyc1(0, 0, 1, LD, 4, X3);
    cyc1(0, 0, 1, LD, 5, X4);
    cyc1(0, 0, 1, LD, 6, M5);
    cyc1(0, 0, 0, LD, 7, L6S);
    cyc1(0, 0, 0, LD, 7, L6S);
    cyc1(0, 0, 0, LD, 7, L6S);
    cyc1(0, 0, 1, LD, 7, L6);
    cyc1(0, 0, 1, LD, 8, L7);
    cyc1(0, 0, 1, LD, 1, F0);
    cyc1(0, 0, 1, LD, 2, F1);
    cyc1(0, 0, 1, LD, 3, F2);
    cyc1(0, 0, 1, LD, 4, X3);
    cyc1(0, 0, 1, LD, 5, X4);
    cyc1(0, 0, 1, LD, 6, M5);
    cyc1(0, 0, 0, LD, 7, L6S);
    cyc1(0, 1, 0, LD, 7, L6S);
    cyc1(0, 1, 0, LD, 0, 0);
    cyc1(0, 0, 1, ST, 0, 0);
    cyc1(0, 0, 1, ST, 0, 0);
    cyc1(1, 0, 1, ST, 0, 0);
    cyc1(0, 0, 1, ST, 1, F0);
    cyc1(0, 0, 1, ST, 2, F1);
    cyc1(0, 0, 1, ST, 3, F2);
    cyc1(0, 0, 1, ILL, 4, X3);
    cyc1(0, 0, 1, ILL, 5, X4);
    cyc1(0, 0, 1, ILL, 6, M5);
    cyc1(0, 0, 1, ILL, 7, S6);
    cyc1(0, 0, 1, ILL, 8, S7);
    cyc1(0, 0, 1, ILL, 1, F0);
    cyc1(0, 0, 1, ILL, 2, F1);
    cyc1(0, 0, 1, ILL, 3, F2);
    cyc1(0, 0, 1, HLT, 1, F0 | IL);
    cyc1(0, 0, 1, HLT, 2, F1);
    cyc1(0, 0, 1, HLT, 3, F2);
    cyc1(0, 0, 1, HLT, 15, 0);
    cyc1(0, 0, 1, HLT, 15, 0);
    cyc1(1, 0, 1, HLT, 15, 0);
    cyc1(0, 0, 1, NOP, 1, F0);
    cyc1(1, 0, 1, NOP, 2, F1);
    cyc1(0, 0, 1, NOP, 3, F2);
    cyc1(0, 0, 1, HLT, 1, F0);
    cyc1(0, 0, 0, HLT, 2, F1S);
    cyc1(0, 0, 1, HLT, 2, F1);
    cyc1(0, 0, 1, HLT, 3, F2);
    cyc1(0, 0, 1, HLT, 15, 0);

    cyc2(1, LDI, 0, 0);
    cyc2(0, LDI, 1, PO | RN);
    cyc2(0, LDI, 1, F0);
    cyc2(0, LDI, 2, F1S);
    cyc2(0, LDI, 2, F1);
    cyc2(0, LDI, 3, MDO | RN);
    cyc2(0, LDI, 3, F2);
    cyc2(0, HLT, 4, GRB | BA | RN);
    cyc2(0, HLT, 4, X3);
    cyc2(0, HLT, 5, CSE | RN);
    cyc2(0, HLT, 5, X4);
    cyc2(0, HLT, 6, ZLO | GRA | RN);
    cyc2(0, HLT, 6, I5);
    cyc2(0, HLT, 1, PO | RN);
    cyc2(0, HLT, 1, F0);
    cyc2(0, HLT, 2, F1S);
    cyc2(0, HLT, 2, F1);
    cyc2(0, HLT, 3, MDO | RN);
    cyc2(0, HLT, 3, F2);
    cyc2(0, HLT, 15, 0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0",
               q1.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
